// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - integer clock divider with boundary-aligned ratio changes, bypass and period tick
module clk_div_gen #(
  parameter int WIDTH = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_div_clk,
  output logic             o_period_tick,
  output logic [WIDTH-1:0] o_ratio_active
);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_BYPASS = 2'd1;
  localparam logic [1:0] ST_DIVIDE = 2'd2;

  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ONE_W1 = {{WIDTH{1'b0}}, 1'b1};

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_ratio;
  logic             r_div_q;
  logic             r_tick;

  logic             w_ratio_ge2;
  logic [WIDTH:0]   w_half;
  logic [WIDTH:0]   w_cnt_next;
  logic             w_last;

  // Ratios 0 and 1 both mean bypass, so anything with an upper bit set divides.
  assign w_ratio_ge2 = |i_div_ratio[WIDTH-1:1];
  // One extra bit keeps R+1 from wrapping at the maximum ratio.
  assign w_half      = ({1'b0, r_ratio} + ONE_W1) >> 1;
  assign w_cnt_next  = {1'b0, r_cnt} + ONE_W1;
  assign w_last      = (r_cnt == (r_ratio - ONE_W));

  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_ratio <= '0;
      r_div_q <= 1'b0;
      r_tick  <= 1'b0;
    end else if (!i_clk_en) begin
      r_state <= ST_OFF;
      r_ratio <= i_div_ratio;
      r_cnt   <= '0;
      r_div_q <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      case (r_state)
        ST_OFF, ST_BYPASS: begin
          r_ratio <= i_div_ratio;
          r_cnt   <= '0;
          if (w_ratio_ge2) begin
            r_state <= ST_DIVIDE;
            r_div_q <= 1'b1;
            r_tick  <= 1'b1;
          end else begin
            r_state <= ST_BYPASS;
            r_div_q <= 1'b0;
            r_tick  <= 1'b0;
          end
        end
        ST_DIVIDE: begin
          if (w_last) begin
            // Period boundary: the only point where a new ratio is accepted.
            r_ratio <= i_div_ratio;
            r_cnt   <= '0;
            if (w_ratio_ge2) begin
              r_div_q <= 1'b1;
              r_tick  <= 1'b1;
            end else begin
              r_state <= ST_BYPASS;
              r_div_q <= 1'b0;
              r_tick  <= 1'b0;
            end
          end else begin
            r_cnt   <= w_cnt_next[WIDTH-1:0];
            r_div_q <= (w_cnt_next < w_half);
            r_tick  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_OFF;
          r_cnt   <= '0;
          r_div_q <= 1'b0;
          r_tick  <= 1'b0;
        end
      endcase
    end
  end

  // Combinational mux so dropping the enable hands back the reference clock at once.
  assign o_div_clk      = (i_clk_en && (r_state == ST_DIVIDE)) ? r_div_q : i_ref_clk;
  assign o_period_tick  = r_tick;
  assign o_ratio_active = r_ratio;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed scoreboard bench for clk_div_gen
module tb_clk_div_gen;

  localparam int WIDTH = 8;

  logic             i_ref_clk = 1'b0;
  logic             i_rst_n;
  logic             i_clk_en;
  logic [WIDTH-1:0] i_div_ratio;
  logic             o_div_clk;
  logic             o_period_tick;
  logic [WIDTH-1:0] o_ratio_active;

  typedef struct {
    logic       div;
    logic       tick;
    logic [7:0] ratio;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  clk_div_gen #(.WIDTH(WIDTH)) dut (
    .i_ref_clk     (i_ref_clk),
    .i_rst_n       (i_rst_n),
    .i_clk_en      (i_clk_en),
    .i_div_ratio   (i_div_ratio),
    .o_div_clk     (o_div_clk),
    .o_period_tick (o_period_tick),
    .o_ratio_active(o_ratio_active)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic div, input logic tick, input logic [7:0] ratio);
    exp_t e;
    e.div   = div;
    e.tick  = tick;
    e.ratio = ratio;
    sb.push_back(e);
  endtask

  // One divided period of ratio n: H=ceil(n/2) high cycles then the rest low.
  task automatic push_period(input int n, input int k = -1);
    int h;
    int lim;
    h   = (n + 1) / 2;
    lim = (k < 0) ? n : k;
    for (int i = 0; i < lim; i++) push(i < h, i == 0, 8'(n));
  endtask

  task automatic run(input int k);
    exp_t e;
    for (int i = 0; i < k; i++) begin
      @(posedge i_ref_clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("div_clk", {31'd0, o_div_clk}, {31'd0, e.div});
        chk("tick", {31'd0, o_period_tick}, {31'd0, e.tick});
        chk("ratio", {24'd0, o_ratio_active}, {24'd0, e.ratio});
      end
    end
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_clk_en    = 1'b1;
    i_div_ratio = 8'd4;
    repeat (2) @(posedge i_ref_clk);
    #1;
    chk("rst_tick", {31'd0, o_period_tick}, 32'd0);
    chk("rst_ratio", {24'd0, o_ratio_active}, 32'd0);
    chk("rst_clk_hi", {31'd0, o_div_clk}, 32'd1);
    @(negedge i_ref_clk);
    #1;
    chk("rst_clk_lo", {31'd0, o_div_clk}, 32'd0);
    i_rst_n = 1'b1;

    // N=4 from reset
    push_period(4); push_period(4); push_period(4);
    run(12);

    // N=5, then N=255 with a mid-period request that must wait for the boundary
    i_div_ratio = 8'd5;
    push_period(5); push_period(5);
    run(10);
    i_div_ratio = 8'd255;
    push_period(255);
    run(1);
    i_div_ratio = 8'd4;
    run(254);
    push_period(4); push_period(4);
    run(8);

    // ratio change 4 -> 6 at cnt=1
    push_period(4); push_period(6); push_period(6);
    run(2);
    i_div_ratio = 8'd6;
    run(14);

    // bypass with N=1 then N=0, then N=3
    i_div_ratio = 8'd1;
    push(1, 0, 8'd1); push(1, 0, 8'd1); push(1, 0, 8'd1);
    run(3);
    @(negedge i_ref_clk);
    #1;
    chk("byp1_clk_lo", {31'd0, o_div_clk}, 32'd0);
    chk("byp1_tick_lo", {31'd0, o_period_tick}, 32'd0);
    i_div_ratio = 8'd0;
    push(1, 0, 8'd0); push(1, 0, 8'd0);
    run(2);
    @(negedge i_ref_clk);
    #1;
    chk("byp0_clk_lo", {31'd0, o_div_clk}, 32'd0);
    i_div_ratio = 8'd3;
    push_period(3); push_period(3);
    run(6);

    // N=6, drop enable at cnt=2 (high phase)
    i_div_ratio = 8'd6;
    push_period(6, 3);
    run(3);
    i_clk_en = 1'b0;
    @(negedge i_ref_clk);
    #1;
    chk("en_drop_clk_lo", {31'd0, o_div_clk}, 32'd0);
    push(1, 0, 8'd6); push(1, 0, 8'd6);
    run(2);
    i_clk_en = 1'b1;
    push_period(6);
    run(6);

    // N=8, async reset at the tick cycle
    i_div_ratio = 8'd8;
    push_period(8, 1);
    run(1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_tick", {31'd0, o_period_tick}, 32'd0);
    chk("arst_ratio", {24'd0, o_ratio_active}, 32'd0);
    chk("arst_clk_hi", {31'd0, o_div_clk}, 32'd1);
    @(negedge i_ref_clk);
    #1;
    chk("arst_clk_lo", {31'd0, o_div_clk}, 32'd0);
    i_rst_n = 1'b1;
    push_period(8); push_period(8);
    run(16);

    chk("sb_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
Parametrised integer clock divider producing a divided clock from i_ref_clk for the low-power multi-clock system, e.g. UART TX/RX clocks. It extends the basic divider with the following:
- a wider ratio range;
- odd-ratio support with defined duty;
- ratio changes that take effect only at a period boundary, so no runt pulses;
- explicit bypass for ratios 0/1;
- a per-period tick output and a readback of the active ratio.

All sequential logic is on the rising edge of i_ref_clk.

Parameters:
WIDTH, 8, width of ratio input and internal counter; supported ratio range 2..2^WIDTH-1 (0/1 = bypass).

Ports:
i_ref_clk  in  1  reference clock.
i_rst_n  in  1  reset; asynchronous, active-low.
i_clk_en  in  1  divider enable; low = output follows i_ref_clk.
i_div_ratio  in  WIDTH  requested division ratio N.
o_div_clk  out  1  divided clock (or i_ref_clk when disabled/bypass).
o_period_tick  out  1  one-ref-cycle pulse at the start of every divided period (DIVIDE state only).
o_ratio_active  out  WIDTH  ratio currently in effect (R).

Behaviour:
- Reset (async, i_rst_n=0): state=OFF, cnt=0, R=0, div_q=0, tick=0.
  - o_div_clk = i_ref_clk (OFF state mux).
  - o_period_tick=0, o_ratio_active=0.
- Output mux (combinational): o_div_clk = (i_clk_en && state==DIVIDE) ? div_q : i_ref_clk.
  - Dropping i_clk_en switches the output to i_ref_clk immediately, without waiting for an edge.
- Half-period: H = (R+1)>>1, computed in WIDTH+1 bits. High phase = H cycles, low phase = R-H cycles.
  - Even N: 50% duty.
  - Odd N: high one cycle longer than low.
- State OFF (i_clk_en=0 sampled):
  - Each posedge: R<=i_div_ratio, cnt<=0, div_q<=0, tick<=0.
  - On posedge with i_clk_en=1:
    - i_div_ratio<2 -> BYPASS.
    - Else -> DIVIDE entry.
- DIVIDE entry, common to all entry paths: R<=i_div_ratio, cnt<=0, div_q<=1, tick<=1.
- State BYPASS:
  - R<=i_div_ratio every posedge; div_q=0, tick=0.
  - If i_div_ratio>=2 -> DIVIDE entry at that posedge.
- State DIVIDE, each posedge:
  - cnt!=R-1: cnt<=cnt+1, div_q<=((cnt+1)<H), tick<=0.
  - cnt==R-1 (period boundary): R<=i_div_ratio sampled now.
    - If new value>=2: cnt<=0, div_q<=1, tick<=1.
    - If new value<2: -> BYPASS, div_q<=0, tick<=0.
  - i_div_ratio changes between boundaries are ignored until the next boundary. The current period always completes with the old R.
- i_clk_en=0 sampled in any state -> OFF at that posedge, regardless of cnt. The in-progress period is abandoned.
- o_period_tick and div_q are registered and rise on the same posedge. The tick is high for exactly 1 ref cycle per divided period.
- Max ratio 2^WIDTH-1: cnt reaches 2^WIDTH-2 and never overflows. The R-1 compare is done in WIDTH bits and is valid because R>=2 in DIVIDE.
- Reset asserted mid-period: all registers clear immediately; the output reverts to i_ref_clk. After release the block restarts from OFF.
- Period accuracy in DIVIDE: every divided period is exactly R ref cycles, measured rising edge to rising edge of div_q.

Test Plan:
1. WIDTH=8, en=1, N=4 from reset -> o_div_clk pattern 1,1,0,0 repeating; tick every 4 cycles aligned with rising div_q; o_ratio_active=4.
2. N=5 -> high 3 cycles, low 2 cycles, period 5. N=255 -> high 128, low 127, no cnt overflow.
3. Running N=4, change i_div_ratio to 6 at cnt=1 -> current period finishes as 2H/2L. The next period is 3H/3L; o_ratio_active updates at that boundary only.
4. N=1 and N=0 with en=1 -> o_div_clk==i_ref_clk, tick=0. Change to N=3 -> DIVIDE entry on the next posedge; first period is 2H/1L.
5. Running N=6, drop en at cnt=2 -> o_div_clk follows i_ref_clk immediately; state OFF. Re-enable -> fresh period starting high, tick=1 on entry.
6. Assert i_rst_n=0 mid-high-phase (N=8) -> cnt/R/div_q/tick clear asynchronously without waiting for an edge; o_div_clk=i_ref_clk. After release + en=1 -> clean 4H/4L periods.
